// File: rtl/ex_mem_pkg.sv
// Shared EX/MEM payload definitions: field widths, memory-op encodings and the idle payload.
// Used by ex_mem_queue and ex_mem_byp_lookup.
package ex_mem_pkg;

  localparam int EX_MEM_DATA_W  = 32;
  localparam int EX_MEM_ADDR_W  = 5;
  localparam int EX_MEM_MEMOP_W = 2;

  typedef enum logic [EX_MEM_MEMOP_W-1:0] {
    MEM_OP_NOP    = 2'd0,
    MEM_OP_LOAD   = 2'd1,
    MEM_OP_STORE  = 2'd2,
    MEM_OP_ATOMIC = 2'd3
  } mem_op_e;

  typedef struct packed {
    logic                      en;
    logic [EX_MEM_MEMOP_W-1:0] mem_op;
    logic [EX_MEM_DATA_W-1:0]  mem_wr_data;
    logic [EX_MEM_ADDR_W-1:0]  dst_addr;
    logic                      gpr_we_;
    logic [EX_MEM_DATA_W-1:0]  out;
  } ex_mem_payload_t;

  localparam ex_mem_payload_t EX_MEM_IDLE = '{
    en:          1'b0,
    mem_op:      MEM_OP_NOP,
    mem_wr_data: '0,
    dst_addr:    '0,
    gpr_we_:     1'b1,
    out:         '0
  };

  function automatic logic is_load(input logic [EX_MEM_MEMOP_W-1:0] op);
    return op == MEM_OP_LOAD;
  endfunction

endpackage

// File: rtl/ex_mem_byp_lookup.sv
// Youngest-first GPR forwarding match over the resident EX/MEM queue entries.
// Only instantiated when EX_MEM_QUEUE_BYP_EN is defined.
module ex_mem_byp_lookup
  import ex_mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  ex_mem_payload_t [DEPTH-1:0]  ent,
  input  logic [PW-1:0]                head,
  input  logic [CW-1:0]                count,
  input  logic [EX_MEM_ADDR_W-1:0]     rd_addr,
  output logic                         hit,
  output logic                         load,
  output logic [EX_MEM_DATA_W-1:0]     data
);

  logic [DEPTH-1:0] slot_match;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign slot_match[g] = ent[g].en & ~ent[g].gpr_we_ & (ent[g].dst_addr == rd_addr);
  end

  // Walk oldest to youngest from head; later hits overwrite, so the youngest wins.
  always_comb begin
    hit  = 1'b0;
    load = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] s;
      s = PW'((int'(head) + i) % DEPTH);
      if (i < int'(count) && slot_match[s] && rd_addr != '0) begin
        hit  = 1'b1;
        load = is_load(ent[s].mem_op);
        data = ent[s].out;
      end
    end
  end

endmodule

// File: rtl/ex_mem_queue.sv
// Elastic valid/ready EX/MEM queue of DEPTH payload entries with global stall/flush.
// Define EX_MEM_QUEUE_BYP_EN to add the youngest-pending-write bypass lookup port.
module ex_mem_queue
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = EX_MEM_DATA_W,
  parameter int ADDR_W  = EX_MEM_ADDR_W,
  parameter int MEMOP_W = EX_MEM_MEMOP_W,
  parameter int DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_en,
  input  logic                         in_gpr_we_,
  input  logic [MEMOP_W-1:0]           in_mem_op,
  input  logic [ADDR_W-1:0]            in_dst_addr,
  input  logic [DATA_W-1:0]            in_mem_wr_data,
  input  logic [DATA_W-1:0]            in_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_en,
  output logic                         out_gpr_we_,
  output logic [MEMOP_W-1:0]           out_mem_op,
  output logic [ADDR_W-1:0]            out_dst_addr,
  output logic [DATA_W-1:0]            out_mem_wr_data,
  output logic [DATA_W-1:0]            out_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef EX_MEM_QUEUE_BYP_EN
  ,
  input  logic [ADDR_W-1:0]            byp_rd_addr,
  output logic                         byp_hit,
  output logic                         byp_load,
  output logic [DATA_W-1:0]            byp_data
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ex_mem_payload_t [DEPTH-1:0] mem;
  ex_mem_payload_t             in_pl, head_pl;
  logic [PW-1:0]               head, tail;
  logic [CW-1:0]               cnt;
  logic                        push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake status comes only from registered count: no out_ready -> in_ready path.
  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready & ~stall & ~flush;
  assign pop       = out_valid & out_ready & ~stall & ~flush;

  assign in_pl = '{
    en:          in_en,
    mem_op:      in_mem_op,
    mem_wr_data: in_mem_wr_data,
    dst_addr:    in_dst_addr,
    gpr_we_:     in_gpr_we_,
    out:         in_out
  };

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= EX_MEM_IDLE;
    end else if (!stall) begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i].gpr_we_ <= 1'b1;
      end else begin
        if (push) begin
          mem[tail] <= in_pl;
          tail      <= nxt(tail);
        end
        if (pop) head <= nxt(head);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  assign head_pl         = out_valid ? mem[head] : EX_MEM_IDLE;
  assign out_en          = head_pl.en;
  assign out_gpr_we_     = head_pl.gpr_we_;
  assign out_mem_op      = head_pl.mem_op;
  assign out_dst_addr    = head_pl.dst_addr;
  assign out_mem_wr_data = head_pl.mem_wr_data;
  assign out_out         = head_pl.out;
  assign count           = cnt;

`ifdef EX_MEM_QUEUE_BYP_EN
  ex_mem_byp_lookup #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_byp (
    .ent     (mem),
    .head    (head),
    .count   (cnt),
    .rd_addr (byp_rd_addr),
    .hit     (byp_hit),
    .load    (byp_load),
    .data    (byp_data)
  );
`endif

endmodule
